// File: rtl/iotile_config_loader.sv
// Serial configuration loader for the IO tile: shifts a bitstream LSB-first,
// passes overflow bits down the daisy chain and commits whole frames to config_out.
module iotile_config_loader #(
    parameter int CONFIG_WIDTH = 36
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    config_shift_en,
    input  logic                    config_bit_in,
    output logic                    config_bit_out,
    input  logic                    config_commit,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    config_loaded,
    output logic                    frame_error
);

    localparam int CNT_W = $clog2(CONFIG_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CONFIG_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_next;
    logic [CONFIG_WIDTH-1:0] sr;
    logic                    commit_ok;
    logic                    commit_bad;

    // state always mirrors cnt: EMPTY at 0, FULL at CONFIG_WIDTH, PARTIAL between
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= EMPTY;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        commit_ok  = 1'b0;
        commit_bad = 1'b0;
        if (config_commit) begin
            // commit judges the pre-edge frame; a concurrent shift starts the next one
            commit_ok  = (state == FULL);
            commit_bad = (state != FULL);
            if (config_shift_en) begin
                cnt_next   = CNT_ONE;
                state_next = PARTIAL;
            end else begin
                cnt_next   = '0;
                state_next = EMPTY;
            end
        end else if (config_shift_en && state != FULL) begin
            cnt_next   = cnt + CNT_ONE;
            state_next = (cnt + CNT_ONE == CNT_FULL) ? FULL : PARTIAL;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sr            <= '0;
            config_out    <= '0;
            config_loaded <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            if (config_shift_en) begin
                sr <= {config_bit_in, sr[CONFIG_WIDTH-1:1]};
            end
            if (commit_ok) begin
                config_out <= sr;
            end
            config_loaded <= commit_ok;
            if (commit_ok) begin
                frame_error <= 1'b0;
            end else if (commit_bad) begin
                frame_error <= 1'b1;
            end
        end
    end

    assign config_bit_out = sr[0];

endmodule

// File: tb/tb_iotile_config_loader.sv
// Scoreboard bench for iotile_config_loader: directed frames, expected values
// queued by the stimulus and compared by an independent negedge monitor.
module tb_iotile_config_loader;

    localparam int W = 36;

    logic          clock = 1'b0;
    logic          reset;
    logic          config_shift_en;
    logic          config_bit_in;
    logic          config_bit_out;
    logic          config_commit;
    logic [W-1:0]  config_out;
    logic          config_loaded;
    logic          frame_error;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int           cyc;
        string        name;
        int           sel;
        logic [W-1:0] exp;
    } chk_t;

    chk_t         chk_q[$];
    chk_t         keep_q[$];
    logic [W-1:0] loaded_q[$];
    logic [W-1:0] cur_out;

    localparam int S_OUT = 0, S_LOADED = 1, S_FE = 2, S_BIT = 3, S_CNT = 4;

    iotile_config_loader #(.CONFIG_WIDTH(W)) dut (
        .clock           (clock),
        .reset           (reset),
        .config_shift_en (config_shift_en),
        .config_bit_in   (config_bit_in),
        .config_bit_out  (config_bit_out),
        .config_commit   (config_commit),
        .config_out      (config_out),
        .config_loaded   (config_loaded),
        .frame_error     (frame_error)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [W-1:0] actual(int sel);
        case (sel)
            S_OUT:    return config_out;
            S_LOADED: return W'(config_loaded);
            S_FE:     return W'(frame_error);
            S_BIT:    return W'(config_bit_out);
            default:  return W'(dut.cnt);
        endcase
    endfunction

    function automatic void expect_at(int c, string n, int sel, logic [W-1:0] v);
        chk_t e;
        e.cyc = c; e.name = n; e.sel = sel; e.exp = v;
        chk_q.push_back(e);
    endfunction

    // monitor: compares due entries and every config_loaded pulse
    always @(negedge clock) begin
        logic [W-1:0] a;
        logic [W-1:0] e;
        keep_q.delete();
        foreach (chk_q[i]) begin
            if (chk_q[i].cyc == cyc) begin
                a = actual(chk_q[i].sel);
                tests++;
                if (a !== chk_q[i].exp) begin
                    fails++;
                    $display("FAIL %s @cyc %0d: got %h expected %h", chk_q[i].name, cyc, a, chk_q[i].exp);
                end
            end else if (chk_q[i].cyc < cyc) begin
                tests++;
                fails++;
                $display("FAIL %s: check for cyc %0d never evaluated", chk_q[i].name, chk_q[i].cyc);
            end else begin
                keep_q.push_back(chk_q[i]);
            end
        end
        chk_q = keep_q;
        if (config_loaded === 1'b1) begin
            tests++;
            if (loaded_q.size() == 0) begin
                fails++;
                $display("FAIL loaded_pulse: got unexpected pulse with config_out %h expected no pulse", config_out);
            end else begin
                e = loaded_q.pop_front();
                if (config_out !== e) begin
                    fails++;
                    $display("FAIL loaded_value: got %h expected %h", config_out, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic shift_word(input logic [W-1:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            config_shift_en = 1'b1;
            config_bit_in   = v[i];
            tick();
        end
        config_shift_en = 1'b0;
        config_bit_in   = 1'b0;
    endtask

    task automatic commit_good(input logic [W-1:0] v, input string n);
        loaded_q.push_back(v);
        config_commit = 1'b1;
        tick();
        config_commit = 1'b0;
        cur_out = v;
        expect_at(cyc, {n, "_out"}, S_OUT, v);
        expect_at(cyc, {n, "_loaded"}, S_LOADED, 1);
        expect_at(cyc, {n, "_fe"}, S_FE, 0);
        expect_at(cyc, {n, "_cnt"}, S_CNT, 0);
        expect_at(cyc + 1, {n, "_loaded_drop"}, S_LOADED, 0);
    endtask

    task automatic commit_bad(input string n);
        config_commit = 1'b1;
        tick();
        config_commit = 1'b0;
        expect_at(cyc, {n, "_out"}, S_OUT, cur_out);
        expect_at(cyc, {n, "_loaded"}, S_LOADED, 0);
        expect_at(cyc, {n, "_fe"}, S_FE, 1);
        expect_at(cyc, {n, "_cnt"}, S_CNT, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] a_word;
        logic [W-1:0] b_word;
        reset = 1'b1; config_shift_en = 1'b0; config_bit_in = 1'b0; config_commit = 1'b0;
        cur_out = '0;
        tick(); tick();
        expect_at(cyc, "rst_out", S_OUT, 0);
        expect_at(cyc, "rst_loaded", S_LOADED, 0);
        expect_at(cyc, "rst_fe", S_FE, 0);
        expect_at(cyc, "rst_bit", S_BIT, 0);
        expect_at(cyc, "rst_cnt", S_CNT, 0);
        tick();
        reset = 1'b0;
        tick();

        // full load
        shift_word(36'h9A5C3F00D, W);
        expect_at(cyc, "full_cnt", S_CNT, W);
        expect_at(cyc, "full_bit", S_BIT, 1);
        tick();
        commit_good(36'h9A5C3F00D, "full");
        tick(); tick();

        // short frame then recovery
        shift_word(36'hFFFFF, 20);
        expect_at(cyc, "short_cnt", S_CNT, 20);
        tick();
        commit_bad("short");
        tick(); tick();
        shift_word(36'h000000001, W);
        commit_good(36'h000000001, "recover");
        tick(); tick();

        // daisy chain: first word drains out of config_bit_out during the second
        a_word = 36'h123456789;
        b_word = 36'hFEDCBA987;
        shift_word(a_word, W);
        for (int i = 0; i < W; i++) begin
            expect_at(cyc, "daisy_bit", S_BIT, W'(a_word[i]));
            expect_at(cyc, "daisy_cnt", S_CNT, W);
            config_shift_en = 1'b1;
            config_bit_in   = b_word[i];
            tick();
        end
        config_shift_en = 1'b0;
        expect_at(cyc, "daisy_cnt_end", S_CNT, W);
        commit_good(b_word, "daisy");
        tick(); tick();

        // shift and commit in the same cycle
        shift_word(36'hAAAAAAAAA, W);
        loaded_q.push_back(36'hAAAAAAAAA);
        config_commit = 1'b1; config_shift_en = 1'b1; config_bit_in = 1'b1;
        tick();
        config_commit = 1'b0; config_shift_en = 1'b0; config_bit_in = 1'b0;
        cur_out = 36'hAAAAAAAAA;
        expect_at(cyc, "sc_out", S_OUT, 36'hAAAAAAAAA);
        expect_at(cyc, "sc_cnt", S_CNT, 1);
        expect_at(cyc, "sc_fe", S_FE, 0);
        shift_word(36'hFFFFFFFFF, W - 1);
        commit_good(36'hFFFFFFFFF, "sc2");
        tick(); tick();

        // reset mid-operation
        shift_word(36'h0F0F0F0F0, W);
        commit_good(36'h0F0F0F0F0, "pre_rst");
        tick();
        shift_word(36'h3FF, 10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cur_out = '0;
        expect_at(cyc, "mid_rst_out", S_OUT, 0);
        expect_at(cyc, "mid_rst_bit", S_BIT, 0);
        expect_at(cyc, "mid_rst_fe", S_FE, 0);
        expect_at(cyc, "mid_rst_loaded", S_LOADED, 0);
        expect_at(cyc, "mid_rst_cnt", S_CNT, 0);
        commit_bad("post_rst");
        shift_word(36'h5A5A5A5A5, W);
        commit_good(36'h5A5A5A5A5, "after_rst");
        tick();

        // idle stability with toggling input
        for (int i = 0; i < 50; i++) begin
            config_bit_in = i[0];
            tick();
            expect_at(cyc, "idle_out", S_OUT, 36'h5A5A5A5A5);
            expect_at(cyc, "idle_bit", S_BIT, 1);
            expect_at(cyc, "idle_cnt", S_CNT, 0);
        end
        config_bit_in = 1'b0;
        tick(); tick(); tick();

        tests++;
        if (loaded_q.size() != 0) begin
            fails++;
            $display("FAIL loaded_q_drain: got %0d pending pulses expected 0", loaded_q.size());
        end
        tests++;
        if (chk_q.size() != 0) begin
            fails++;
            $display("FAIL chk_q_drain: got %0d pending checks expected 0", chk_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/iotile_config_loader.md
Name: iotile_config_loader

Overview:
- Serial configuration loader that sits directly upstream of the IO tile and drives its 36-bit config_in bus.
- Accepts a one-bit-per-cycle bitstream and forwards the bits it shifts out to the next tile in the daisy chain.
- Writes the captured frame into a separate active register on commit, so the IO tile muxes never see a partial frame while bits are shifting.
- Flags frames whose length is wrong.

Parameters:
- CONFIG_WIDTH, 36: number of configuration bits per frame. Must match the IO tile config_in width and be ≥ 2.

Ports:
- clock, input, 1: single clock; every register updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- config_shift_en, input, 1: shift config_bit_in into the shift register this cycle.
- config_bit_in, input, 1: serial configuration bit.
- config_bit_out, output, 1: serial output to the next tile, equal to shift-register bit 0.
- config_commit, input, 1: transfer the shift register to config_out.
- config_out, output, CONFIG_WIDTH: active configuration; drives the IO tile config_in.
- config_loaded, output, 1: one-cycle pulse after a successful commit.
- frame_error, output, 1: sticky flag set by a commit with a wrong bit count.

Behaviour:
- Reset: shift register sr, config_out, bit counter cnt, config_loaded and frame_error all go to 0. config_bit_out therefore reads 0. Reset has priority over every other input in the same cycle.
- Shift: when config_shift_en=1, sr <= {config_bit_in, sr[W-1:1]}.
  - Bits enter at the MSB and move toward the LSB.
  - After W shifts, the first bit shifted in sits at sr[0], so frames are sent LSB-first.
  - config_bit_out = sr[0], a registered value with no combinational path from config_bit_in.
- Counter: cnt is ceil(log2(W+1)) bits wide.
  - Increments on each shift while cnt < W.
  - Saturates at W.
- States, derived from cnt:
  - EMPTY (cnt=0): no frame bits held.
  - PARTIAL (0<cnt<W): frame incomplete.
  - FULL (cnt=W): frame complete.
- Transitions:
  - EMPTY→PARTIAL on a shift.
  - PARTIAL→FULL on the W-th shift.
  - Shifts while FULL keep moving bits through sr and out of config_bit_out; cnt stays at W. This is daisy-chain pass-through.
  - Any commit returns to EMPTY, or to PARTIAL with cnt=1 if a shift happens in the same cycle.
- Commit when cnt=W (pre-edge value):
  - config_out <= sr (pre-shift value).
  - config_loaded=1 in the following cycle only.
  - frame_error <= 0.
  - cnt <= 0, or 1 if config_shift_en is also 1.
- Commit when cnt≠W:
  - config_out is unchanged and config_loaded stays 0.
  - frame_error <= 1.
  - cnt <= 0, or 1 with a simultaneous shift.
- Simultaneous shift and commit:
  - The commit uses sr and cnt as they were before the edge.
  - The shift still takes effect in sr, and the new bit counts as bit 1 of the next frame.
- Latency: config_out and config_loaded change one cycle after the clock edge that samples config_commit.
- config_out stays stable between commits, regardless of shift activity.
- frame_error is sticky; only reset or a successful commit clears it.
- Reset mid-frame discards the partial frame. config_out returns to 0, which selects mux input 0 on every IO tile mux.
- config_loaded never stays high for two consecutive cycles unless two consecutive valid commits occur. That is impossible, because cnt cannot reach W in one cycle after clearing.

Test Plan:
- Full load:
  - Stimulus: reset, shift the 36-bit value 0x9A5C3F00D LSB-first over 36 cycles, then pulse commit.
  - Required response: next cycle config_out=0x9A5C3F00D, config_loaded=1 for exactly one cycle, frame_error=0.
- Short frame:
  - Stimulus: after the full-load test, shift 20 bits, then commit.
  - Required response: config_out stays 0x9A5C3F00D, config_loaded stays 0, frame_error=1. A following correct 36-bit load of 0x000000001 plus commit gives config_out=0x000000001 and frame_error=0.
- Daisy chain:
  - Stimulus: shift 72 bits, first 0x123456789 then 0xFEDCBA987, both LSB-first, then commit.
  - Required response: over shifts 37–72, config_bit_out emits 0x123456789 LSB-first; cnt holds at 36; commit gives config_out=0xFEDCBA987.
- Shift and commit in the same cycle:
  - Stimulus: after 36 shifts of 0xAAAAAAAAA, assert commit and shift (bit=1) together, then shift 35 more bits of all ones and commit.
  - Required response: first commit gives 0xAAAAAAAAA; second commit gives 0xFFFFFFFFF with frame_error=0.
- Reset mid-operation:
  - Stimulus: load and commit 0x0F0F0F0F0, shift 10 bits, assert reset for one cycle.
  - Required response: config_out=0, config_bit_out=0, frame_error=0, config_loaded=0. A commit right after reset sets frame_error=1. A subsequent full load works.
- Idle stability:
  - Stimulus: commit 0x5A5A5A5A5, then toggle config_bit_in for 50 cycles with shift_en=0.
  - Required response: config_out, config_bit_out and cnt stay unchanged.
